hbridge_gate_ctrl: RTL and testbench

HBRIDGE_GATE_CTRL -- requirements
Module: hbridge_gate_ctrl

---
 rtl/hbridge_gate_ctrl.sv | 145 ++++++++++++++
 tb/tb_hbridge_gate_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_gate_ctrl.sv
// hbridge_gate_ctrl: H-bridge gate sequencer with input filtering and dead time.
//   A requested bridge mode (state_in, plus dir when HBG_DIR_EN is defined) is
//   sampled, filtered for FILTER_LEN stable samples and then applied to the gates.
//   Every change of applied mode passes through an all-gates-off interval of
//   DEADTIME cycles.
// Optional feature macro: HBG_DIR_EN adds the dir port (drive forward/reverse).
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   state_in[1:0]  requested mode: 00 brake, 01 short, 10 open, 11 drive
//   dir            drive direction, 0 forward / 1 reverse (HBG_DIR_EN only)
//   gate_hs_a, gate_ls_a, gate_hs_b, gate_ls_b  registered gate enables
//   applied_state[1:0]  mode currently driven on the gates
//   switching      high while the dead interval is running
module hbridge_gate_ctrl #(
  parameter int unsigned DEADTIME   = 16,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state_in,
`ifdef HBG_DIR_EN
  input  logic       dir,
`endif
  output logic       gate_hs_a,
  output logic       gate_ls_a,
  output logic       gate_hs_b,
  output logic       gate_ls_b,
  output logic [1:0] applied_state,
  output logic       switching
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned REQ_W = 3;  // {dir, mode}

  localparam logic [1:0]       MODE_BRAKE = 2'b00;
  localparam logic [1:0]       MODE_SHORT = 2'b01;
  localparam logic [1:0]       MODE_OPEN  = 2'b10;
  localparam logic [1:0]       MODE_DRIVE = 2'b11;
  localparam logic [REQ_W-1:0] REQ_OPEN   = {1'b0, MODE_OPEN};

  typedef enum logic {HOLD, DEAD} state_t;

  logic [REQ_W-1:0] req_c;
  logic [REQ_W-1:0] sample_q;    // input sample register
  logic [REQ_W-1:0] sample_d_q;  // previous sample, used to detect sample changes
  logic [CNT_W-1:0] filt_cnt_q;
  logic [REQ_W-1:0] target_q;
  logic [REQ_W-1:0] pend_q;      // mode the running dead interval leads to
  logic [REQ_W-1:0] applied_q;
  logic [CNT_W-1:0] dead_cnt_q;
  logic [3:0]       gates_q;     // {hs_a, ls_a, hs_b, ls_b}
  state_t           state_q;

`ifdef HBG_DIR_EN
  assign req_c = {dir, state_in};
`else
  assign req_c = {1'b0, state_in};
`endif

  // Direction only matters in drive; clear it elsewhere so a dir toggle in
  // another mode is not seen as a new target.
  function automatic logic [REQ_W-1:0] norm_req(input logic [REQ_W-1:0] r);
    return {r[2] & (r[1:0] == MODE_DRIVE), r[1:0]};
  endfunction

  function automatic logic [3:0] gate_pattern(input logic [REQ_W-1:0] r);
    logic [3:0] p;
    case (r[1:0])
      MODE_BRAKE: p = 4'b0101;
      MODE_SHORT: p = 4'b1010;
      MODE_OPEN:  p = 4'b0000;
      default:    p = r[2] ? 4'b0110 : 4'b1001;
    endcase
    return p;
  endfunction

  // Input sampling and stability filter; the target is taken once the sample
  // has been unchanged for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q   <= '0;
      sample_d_q <= '0;
      filt_cnt_q <= '0;
      target_q   <= REQ_OPEN;
    end else begin
      sample_q   <= req_c;
      sample_d_q <= sample_q;
      if (sample_q != sample_d_q) begin
        filt_cnt_q <= CNT_W'(1);
      end else if (filt_cnt_q < CNT_W'(FILTER_LEN)) begin
        filt_cnt_q <= filt_cnt_q + CNT_W'(1);
      end
      if (filt_cnt_q == CNT_W'(FILTER_LEN)) begin
        target_q <= norm_req(sample_d_q);
      end
    end
  end

  // Gate sequencer: any target change forces gates off for DEADTIME cycles;
  // a target change during the interval restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HOLD;
      dead_cnt_q <= '0;
      pend_q     <= REQ_OPEN;
      applied_q  <= REQ_OPEN;
      gates_q    <= '0;
      switching  <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (target_q != applied_q) begin
            state_q    <= DEAD;
            dead_cnt_q <= CNT_W'(DEADTIME);
            pend_q     <= target_q;
            gates_q    <= '0;
            switching  <= 1'b1;
          end
        end
        DEAD: begin
          if (target_q != pend_q) begin
            dead_cnt_q <= CNT_W'(DEADTIME);
            pend_q     <= target_q;
          end else if (dead_cnt_q == CNT_W'(1)) begin
            state_q    <= HOLD;
            dead_cnt_q <= '0;
            applied_q  <= pend_q;
            gates_q    <= gate_pattern(pend_q);
            switching  <= 1'b0;
          end else begin
            dead_cnt_q <= dead_cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign gate_hs_a     = gates_q[3];
  assign gate_ls_a     = gates_q[2];
  assign gate_hs_b     = gates_q[1];
  assign gate_ls_b     = gates_q[0];
  assign applied_state = applied_q[1:0];

endmodule

// File: tb/tb_hbridge_gate_ctrl.sv
// Testbench for hbridge_gate_ctrl: directed scenarios plus randomized mode
// sequences, checked every cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_hbridge_gate_ctrl;

  localparam int unsigned DT = 16;
  localparam int unsigned FL = 4;
  localparam logic [6:0]  RESET_W = 7'b0000_10_0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_in = 2'b10;
  logic       dir_drv = 1'b0;
  logic       gate_hs_a, gate_ls_a, gate_hs_b, gate_ls_b;
  logic [1:0] applied_state;
  logic       switching;

  hbridge_gate_ctrl #(.DEADTIME(DT), .FILTER_LEN(FL)) dut (
    .clk           (clk),
    .reset         (reset),
    .state_in      (state_in),
`ifdef HBG_DIR_EN
    .dir           (dir_drv),
`endif
    .gate_hs_a     (gate_hs_a),
    .gate_ls_a     (gate_ls_a),
    .gate_hs_b     (gate_hs_b),
    .gate_ls_b     (gate_ls_b),
    .applied_state (applied_state),
    .switching     (switching)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: request history per clock edge plus dead-interval end time.
  int   hist[$];
  int   m_tgt, m_app, m_pend, m_end;
  bit   m_busy;
  logic [6:0] exp_w;
  logic [6:0] obs;
  logic       overlap;

  assign obs     = {gate_hs_a, gate_ls_a, gate_hs_b, gate_ls_b, applied_state, switching};
  assign overlap = (gate_hs_a & gate_ls_a) | (gate_hs_b & gate_ls_b);

  function automatic logic [3:0] pat(int t);
    case (t)
      0:       return 4'b0101;
      1:       return 4'b1010;
      3:       return 4'b1001;
      7:       return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int norm(int v);
    return ((v & 3) == 3) ? v : (v & 3);
  endfunction

  task automatic model_reset();
    hist.delete();
    m_tgt = 2; m_app = 2; m_pend = 2; m_end = 0; m_busy = 0;
    exp_w = RESET_W;
  endtask

  // Advance one clock edge, update the model, then sit 1ns after the edge.
  task automatic tick();
    int n, v, old_tgt;
    bit stable;
    @(posedge clk);
    hist.push_back(int'({dir_drv, state_in}));
    n = hist.size();
    old_tgt = m_tgt;
    if (m_busy && old_tgt != m_pend) begin
      m_pend = old_tgt; m_end = n + int'(DT);
    end else if (m_busy && n == m_end) begin
      m_busy = 0; m_app = m_pend;
    end else if (!m_busy && old_tgt != m_app) begin
      m_busy = 1; m_pend = old_tgt; m_end = n + int'(DT);
    end
    // A request is accepted once it was present for FL consecutive edges,
    // and becomes the target two edges after the last of them.
    if (n >= int'(FL) + 2) begin
      v = hist[n-3];
      stable = 1;
      for (int i = n - 1 - int'(FL); i <= n - 2; i++) if (hist[i-1] != v) stable = 0;
      if (stable) m_tgt = norm(v);
    end
    exp_w = {(m_busy ? 4'b0000 : pat(m_app)), 2'(m_app & 3), m_busy};
    #1;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    state_in = 2'b10;
    dir_drv = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs !== RESET_W) begin
      miscompares++; $display("FAIL reset_values obs=%b exp=%b", obs, RESET_W);
    end
    #2 reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++; $display("FAIL reset_idle c=%0d obs=%b exp=%b", c, obs, exp_w);
      end
    end
  endtask

  task automatic test_drive_from_reset();
    int sw_first = -1, sw_cnt = 0, lat = -1;
    apply_reset();
    state_in = 2'b11;
    for (int c = 1; c <= 40; c++) begin
      tick();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++; $display("FAIL drive_model c=%0d obs=%b exp=%b", c, obs, exp_w);
      end
      if (switching) begin
        if (sw_first < 0) sw_first = c;
        sw_cnt++;
      end
      if (lat < 0 && obs[6:3] == 4'b1001 && applied_state == 2'b11) lat = c;
    end
    vectors++;
    if (sw_first !== 7) begin
      miscompares++; $display("FAIL drive_dead_entry got=%0d want=7", sw_first);
    end
    vectors++;
    if (sw_cnt !== int'(DT)) begin
      miscompares++; $display("FAIL drive_dead_len got=%0d want=%0d", sw_cnt, DT);
    end
    vectors++;
    if (lat !== 1 + int'(FL) + 1 + int'(DT) + 1) begin
      miscompares++; $display("FAIL drive_latency got=%0d want=%0d", lat, 1 + FL + 1 + DT + 1);
    end
  endtask

  task automatic test_brake();
    int low = 0;
    state_in = 2'b00;
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++; $display("FAIL brake_model c=%0d obs=%b exp=%b", c, obs, exp_w);
      end
      vectors++;
      if (overlap !== 1'b0) begin
        miscompares++; $display("FAIL brake_overlap c=%0d gates=%b", c, obs[6:3]);
      end
      if (obs[6:3] == 4'b0000) low++;
    end
    vectors++;
    if (low !== int'(DT)) begin
      miscompares++; $display("FAIL brake_low_len got=%0d want=%0d", low, DT);
    end
    vectors++;
    if (obs[6:3] !== 4'b0101) begin
      miscompares++; $display("FAIL brake_final got=%b want=0101", obs[6:3]);
    end
  endtask

  task automatic test_glitch();
    int g;
    for (int r = 0; r < 3; r++) begin
      g = $urandom_range(1, int'(FL) - 1);
      state_in = 2'b11;
      repeat (g) tick();
      state_in = 2'b00;
      for (int c = 0; c < 20; c++) begin
        tick();
        vectors++;
        if (obs !== 7'b0101_00_0) begin
          miscompares++; $display("FAIL glitch_hold g=%0d c=%0d obs=%b exp=0101000", g, c, obs);
        end
        vectors++;
        if (obs !== exp_w) begin
          miscompares++; $display("FAIL glitch_model g=%0d c=%0d obs=%b exp=%b", g, c, obs, exp_w);
        end
      end
    end
  endtask

  task automatic test_retarget();
    int k, low;
    bit seen = 0;
    k = $urandom_range(1, 8);
    state_in = 2'b11;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++; $display("FAIL retarget_model c=%0d obs=%b exp=%b", c, obs, exp_w);
      end
      seen = switching;
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL retarget_no_dead got=0 want=1");
    end
    low = 1;
    repeat (k) begin
      tick();
      if (obs[6:3] == 4'b0000) low++;
    end
    state_in = 2'b01;
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++; $display("FAIL retarget_model2 c=%0d obs=%b exp=%b", c, obs, exp_w);
      end
      if (obs[6:3] == 4'b0000) low++;
    end
    vectors++;
    if (low !== k + int'(FL) + 3 + int'(DT)) begin
      miscompares++; $display("FAIL retarget_low_len k=%0d got=%0d want=%0d", k, low, k + FL + 3 + DT);
    end
    vectors++;
    if (obs[6:3] !== 4'b1010) begin
      miscompares++; $display("FAIL retarget_final got=%b want=1010", obs[6:3]);
    end
  endtask

`ifdef HBG_DIR_EN
  task automatic test_dir();
    int low = 0;
    state_in = 2'b11;
    dir_drv = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    vectors++;
    if (obs !== 7'b1001_11_0) begin
      miscompares++; $display("FAIL dir_fwd obs=%b exp=1001110", obs);
    end
    dir_drv = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++; $display("FAIL dir_model c=%0d obs=%b exp=%b", c, obs, exp_w);
      end
      if (obs[6:3] == 4'b0000) low++;
    end
    vectors++;
    if (low !== int'(DT)) begin
      miscompares++; $display("FAIL dir_low_len got=%0d want=%0d", low, DT);
    end
    vectors++;
    if (obs[6:3] !== 4'b0110) begin
      miscompares++; $display("FAIL dir_final got=%b want=0110", obs[6:3]);
    end
  endtask
`endif

  task automatic test_reset_mid_dead();
    bit seen = 0;
    state_in = (applied_state == 2'b00) ? 2'b11 : 2'b00;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      seen = switching;
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL rstdead_no_dead got=0 want=1");
    end
    repeat (9) tick();  // dead counter now at 7
    vectors++;
    if (obs !== exp_w) begin
      miscompares++; $display("FAIL rstdead_pre obs=%b exp=%b", obs, exp_w);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (obs !== RESET_W) begin
      miscompares++; $display("FAIL rstdead_async obs=%b exp=%b", obs, RESET_W);
    end
    state_in = 2'b10;
    dir_drv = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (switching !== 1'b0 || obs !== exp_w) begin
        miscompares++; $display("FAIL rstdead_after c=%0d obs=%b exp=%b", c, obs, exp_w);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int s = 0; s < 120; s++) begin
      state_in = 2'($urandom_range(0, 3));
`ifdef HBG_DIR_EN
      dir_drv = 1'($urandom_range(0, 1));
`endif
      hold = $urandom_range(1, 28);
      for (int c = 0; c < hold + ((s == 119) ? 40 : 0); c++) begin
        tick();
        vectors++;
        if (obs !== exp_w) begin
          miscompares++; $display("FAIL random_model s=%0d c=%0d obs=%b exp=%b", s, c, obs, exp_w);
        end
        vectors++;
        if (overlap !== 1'b0) begin
          miscompares++; $display("FAIL random_overlap s=%0d c=%0d gates=%b", s, c, obs[6:3]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_drive_from_reset();
    test_brake();
    test_glitch();
    test_retarget();
`ifdef HBG_DIR_EN
    test_dir();
`endif
    test_reset_mid_dead();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
